pio_edge_poll_master: RTL

- Avalon-MM initiator that polls a single-bit input PIO peripheral (data register at address 0, edge-capture register at address 3) over the peripheral's slave port.
- It periodically reads the edge-capture register. When an edge was captured, it clears the register with a write, raises an event pulse and counts the event.
- It then reads the live data register to track the key level.
- It sits between the PIO slave and fabric logic that needs key events without a CPU, such as game or tile-advance logic.

---
 rtl/pio_poll_pkg.sv | 18 +
 rtl/pio_poll_timer.sv | 31 +++
 rtl/pio_edge_poll_master.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pio_poll_pkg.sv
// Shared types and default register addresses for the PIO edge poller.
package pio_poll_pkg;

    // Poll sequence states; encoding is exported on the debug port.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_EDGE   = 3'd1,
        WAIT_EDGE = 3'd2,
        CLR       = 3'd3,
        RD_DATA   = 3'd4,
        WAIT_DATA = 3'd5
    } state_t;

    // Word addresses of the PIO slave registers we touch.
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam logic [1:0] PIO_EDGE_ADDR = 2'd3;

endpackage

// File: rtl/pio_poll_timer.sv
// Poll interval down-counter: reloads on poll start, counts while enabled,
// and sticks at zero (expired) until the next reload.
module pio_poll_timer #(
    parameter int unsigned INTERVAL = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    input  logic reload,
    output logic expired
);

    localparam int TW = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam logic [TW-1:0] LOAD = TW'(INTERVAL - 1);

    logic [TW-1:0] count;

    // Reload wins over counting; counting stops at zero so expiry holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= LOAD;
        end else if (reload) begin
            count <= LOAD;
        end else if (count_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pio_edge_poll_master.sv
// Avalon-MM initiator that polls a PIO edge-capture register, clears captured
// edges, reports them as events, and then samples the live key level.
//
// Bus handshake: there is no waitrequest. A read is a single cycle with
// chipselect=1/write_n=1; readdata is valid READ_LATENCY cycles later, which
// is the last WAIT_* cycle. A write is a single cycle with chipselect=1 and
// write_n=0 and is accepted unconditionally.
module pio_edge_poll_master
    import pio_poll_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter int unsigned READ_LATENCY  = 1,
    parameter logic [1:0]  DATA_ADDR     = PIO_DATA_ADDR,
    parameter logic [1:0]  EDGE_ADDR     = PIO_EDGE_ADDR,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             poll_now,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             key_level,
    output logic             key_event,
    output logic [CNT_W-1:0] event_count,
    output logic             busy,
    output state_t           dbg_state
);

    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] lat_cnt;
    logic       lat_done;
    logic       timer_expired;
    logic       start;

    logic       cs_d;
    logic       write_n_d;
    logic [1:0] addr_d;
    logic       event_d;
    logic       busy_d;

    // Only bit 0 of the slave data carries information.
    logic       readdata_unused;
    assign readdata_unused = ^avm_readdata[31:1];

    assign start    = (state == IDLE) && ((timer_expired && enable) || poll_now);
    assign lat_done = (lat_cnt == 2'd0);

    pio_poll_timer #(
        .INTERVAL (POLL_INTERVAL)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (state == IDLE),
        .reload   (start),
        .expired  (timer_expired)
    );

    // Shared wait counter: armed by each read cycle, runs down through the
    // following WAIT state so lat_done marks the cycle readdata is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= 2'd0;
        end else if ((state == RD_EDGE) || (state == RD_DATA)) begin
            lat_cnt <= LAT_LOAD;
        end else if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the poll sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = RD_EDGE;
            RD_EDGE:   state_next = WAIT_EDGE;
            WAIT_EDGE: if (lat_done) state_next = avm_readdata[0] ? CLR : RD_DATA;
            CLR:       state_next = RD_DATA;
            RD_DATA:   state_next = WAIT_DATA;
            WAIT_DATA: if (lat_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the registered bus signals
    // line up with the state they belong to. Address holds when idle.
    always_comb begin
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = avm_address;
        event_d   = 1'b0;
        busy_d    = (state_next != IDLE);
        case (state_next)
            RD_EDGE: begin
                cs_d   = 1'b1;
                addr_d = EDGE_ADDR;
            end
            CLR: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = EDGE_ADDR;
                event_d   = 1'b1;
            end
            RD_DATA: begin
                cs_d   = 1'b1;
                addr_d = DATA_ADDR;
            end
            default: ;
        endcase
    end

    // Output registers; the event counter steps together with the pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 2'd0;
            key_event      <= 1'b0;
            busy           <= 1'b0;
            event_count    <= '0;
            key_level      <= 1'b0;
        end else begin
            avm_chipselect <= cs_d;
            avm_write_n    <= write_n_d;
            avm_address    <= addr_d;
            key_event      <= event_d;
            busy           <= busy_d;
            if (event_d) begin
                event_count <= event_count + 1'b1;
            end
            if ((state == WAIT_DATA) && lat_done) begin
                key_level <= avm_readdata[0];
            end
        end
    end

    assign avm_writedata = 32'd0;
    assign dbg_state     = state;

endmodule
